// File: rtl/bike_pkg.sv
// bike_pkg: shared distance-unit defaults and residue sizing for the bike computer blocks.
package bike_pkg;
  localparam int UNIT_CM_DEF  = 10000;
  localparam int MIN_KMH_DEF  = 5;
  localparam int TRIP_MAX_DEF = 9999;
  function automatic int res_w(input int unit_cm);
    return $clog2(unit_cm);
  endfunction
endpackage

// File: rtl/reed_debounce.sv
// reed_debounce: synchronises the raw reed switch, accepts a level after DEB_CYC equal samples
// and strobes rise on each accepted low-to-high change.
module reed_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic reed,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic s1_q, s2_q, prev_q, lvl_q, lvl_d, arm_q, arm_d, stable;
  logic [CW-1:0] len_q, len_d;
  // arm blocks the first accepted level after reset unless a stable low was seen first,
  // so a reed already high at reset release never counts as a revolution
  always_comb begin
    len_d  = (s2_q != prev_q) ? CW'(1) : (len_q == CW'(DEB_CYC)) ? len_q : len_q + 1'b1;
    stable = len_d == CW'(DEB_CYC);
    lvl_d  = stable ? s2_q : lvl_q;
    arm_d  = arm_q | stable;
    rise   = stable & s2_q & ~lvl_q & arm_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      lvl_q  <= 1'b0;
      arm_q  <= 1'b0;
      len_q  <= '0;
    end else begin
      s1_q   <= reed;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      lvl_q  <= lvl_d;
      arm_q  <= arm_d;
      len_q  <= len_d;
    end
  end
endmodule

// File: rtl/trip_odometer.sv
// trip_odometer: debounced reed revolutions accumulated into clearable trip registers and a
// saturating total odometer, all in UNIT_CM units with per-accumulator cm residues.
module trip_odometer
  import bike_pkg::*;
#(
  parameter int CIRC_W   = 8,
  parameter int SPEED_W  = 7,
  parameter int N_TRIPS  = 2,
  parameter int TRIP_W   = 14,
  parameter int TRIP_MAX = TRIP_MAX_DEF,
  parameter int TOTAL_W  = 20,
  parameter int UNIT_CM  = UNIT_CM_DEF,
  parameter int MIN_KMH  = MIN_KMH_DEF,
  parameter int DEB_CYC  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reed,
  input  logic [CIRC_W-1:0]         circ,
  input  logic [SPEED_W-1:0]        kmh,
  input  logic [N_TRIPS-1:0]        trip_clr,
  output logic [N_TRIPS*TRIP_W-1:0] trip,
  output logic [TOTAL_W-1:0]        total,
  output logic [N_TRIPS-1:0]        trip_wrap,
  output logic                      rev_pulse
);
  localparam int RW = res_w(UNIT_CM);
  typedef logic [RW:0] sum_t;
  logic rise, rev_pulse_d, rev_pulse_q;
  sum_t add;
  reed_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk  (clk),
    .reset(reset),
    .reed (reed),
    .rise (rise)
  );
  assign add         = sum_t'(circ);
  assign rev_pulse_d = rise && (kmh >= SPEED_W'(MIN_KMH));
  assign rev_pulse   = rev_pulse_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rev_pulse_q <= 1'b0;
    else       rev_pulse_q <= rev_pulse_d;
  end
  // circ < UNIT_CM guarantees at most one unit carry per revolution
  for (genvar i = 0; i < N_TRIPS; i++) begin : g_trip
    logic [RW-1:0] res_q, res_d;
    logic [TRIP_W-1:0] unit_q, unit_d;
    logic wrap_q, wrap_d, carry, at_max;
    sum_t sum;
    always_comb begin
      sum    = {1'b0, res_q} + add;
      carry  = rev_pulse_d && (sum >= sum_t'(UNIT_CM));
      at_max = unit_q == TRIP_W'(TRIP_MAX);
      res_d  = trip_clr[i] ? '0 : rev_pulse_d ? RW'(carry ? sum - sum_t'(UNIT_CM) : sum) : res_q;
      unit_d = trip_clr[i] ? '0 : carry ? (at_max ? '0 : unit_q + 1'b1) : unit_q;
      wrap_d = trip_clr[i] ? 1'b0 : wrap_q | (carry & at_max);
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        res_q  <= '0;
        unit_q <= '0;
        wrap_q <= 1'b0;
      end else begin
        res_q  <= res_d;
        unit_q <= unit_d;
        wrap_q <= wrap_d;
      end
    end
    assign trip[i*TRIP_W +: TRIP_W] = unit_q;
    assign trip_wrap[i]             = wrap_q;
  end
  logic [RW-1:0] tres_q, tres_d;
  logic [TOTAL_W-1:0] tot_q, tot_d;
  logic tcarry;
  sum_t tsum;
  always_comb begin
    tsum   = {1'b0, tres_q} + add;
    tcarry = rev_pulse_d && (tsum >= sum_t'(UNIT_CM));
    tres_d = rev_pulse_d ? RW'(tcarry ? tsum - sum_t'(UNIT_CM) : tsum) : tres_q;
    tot_d  = (tcarry && tot_q != '1) ? tot_q + 1'b1 : tot_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tres_q <= '0;
      tot_q  <= '0;
    end else begin
      tres_q <= tres_d;
      tot_q  <= tot_d;
    end
  end
  assign total = tot_q;
endmodule

// File: tb/tb_trip_odometer.sv
// tb_trip_odometer: directed vector table plus hand sequences for reset, bounce latency,
// wrap, saturation and clear/revolution collisions (small TRIP_MAX and TOTAL_W to reach limits).
module tb_trip_odometer;
  logic clk = 1'b0;
  logic reset, reed;
  logic [7:0] circ;
  logic [6:0] kmh;
  logic [1:0] trip_clr;
  logic [27:0] trip;
  logic [2:0] total;
  logic [1:0] trip_wrap;
  logic rev_pulse;
  int checks = 0;
  int passed = 0;
  int pulses = 0;
  int p0;

  trip_odometer #(.TRIP_MAX(3), .TOTAL_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .reed     (reed),
    .circ     (circ),
    .kmh      (kmh),
    .trip_clr (trip_clr),
    .trip     (trip),
    .total    (total),
    .trip_wrap(trip_wrap),
    .rev_pulse(rev_pulse)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rev_pulse) pulses++;

  typedef struct {
    logic [7:0] circ;
    logic [6:0] kmh;
    int         n;
    logic [1:0] clr;
    int         exp_pulses;
    int         t0, t1, tot;
    logic [1:0] wrap;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic do_rev();
    reed = 1'b1;
    repeat (8) @(posedge clk);
    #1 reed = 1'b0;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int t0, input int t1, input int tot, input int wrap);
    chk({name, " trip0"}, int'(trip[13:0]), t0);
    chk({name, " trip1"}, int'(trip[27:14]), t1);
    chk({name, " total"}, int'(total), tot);
    chk({name, " wrap"}, int'(trip_wrap), wrap);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0]  = '{8'd200, 7'd20, 50,  2'b00, 50,  1, 1, 1, 2'b00};
    v[1]  = '{8'd200, 7'd20, 1,   2'b00, 1,   1, 1, 1, 2'b00};
    v[2]  = '{8'd200, 7'd4,  100, 2'b00, 0,   1, 1, 1, 2'b00};
    v[3]  = '{8'd200, 7'd5,  49,  2'b00, 49,  2, 2, 2, 2'b00};
    v[4]  = '{8'd250, 7'd30, 40,  2'b00, 40,  3, 3, 3, 2'b00};
    v[5]  = '{8'd250, 7'd30, 40,  2'b00, 40,  0, 0, 4, 2'b11};
    v[6]  = '{8'd250, 7'd30, 20,  2'b00, 20,  0, 0, 4, 2'b11};
    v[7]  = '{8'd250, 7'd30, 20,  2'b01, 20,  0, 1, 5, 2'b10};
    v[8]  = '{8'd250, 7'd30, 20,  2'b10, 20,  1, 0, 5, 2'b00};
    v[9]  = '{8'd250, 7'd30, 80,  2'b00, 80,  3, 2, 7, 2'b00};
    v[10] = '{8'd250, 7'd30, 40,  2'b00, 40,  0, 3, 7, 2'b01};
    reset = 1'b1; reed = 1'b1; circ = 8'd0; kmh = 7'd20; trip_clr = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    p0 = pulses;
    repeat (12) @(posedge clk);
    #1;
    chk("reset_high_reed pulses", pulses - p0, 0);
    chk_out("reset", 0, 0, 0, 0);
    reed = 1'b0;
    repeat (10) @(posedge clk);
    #1 reed = 1'b1;
    @(posedge clk); #1 reed = 1'b0;
    @(posedge clk); #1 reed = 1'b1;
    p0 = pulses;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bounce latency k=%0d", k), int'(rev_pulse), int'(k == 6));
    end
    repeat (4) @(posedge clk);
    #1 reed = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("bounce pulses", pulses - p0, 1);
    chk_out("circ0", 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      circ = v[i].circ;
      kmh  = v[i].kmh;
      if (v[i].clr != 2'b00) begin
        trip_clr = v[i].clr;
        @(posedge clk); #1 trip_clr = 2'b00;
      end
      p0 = pulses;
      for (int r = 0; r < v[i].n; r++) do_rev();
      chk($sformatf("vec%0d pulses", i), pulses - p0, v[i].exp_pulses);
      chk_out($sformatf("vec%0d", i), v[i].t0, v[i].t1, v[i].tot, int'(v[i].wrap));
    end
    reed = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk_out("async reset", 0, 0, 0, 0);
    chk("async reset pulse", int'(rev_pulse), 0);
    reed = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    circ = 8'd250; kmh = 7'd30;
    for (int r = 0; r < 39; r++) do_rev();
    chk_out("pre collide", 0, 0, 0, 0);
    reed = 1'b1;
    repeat (5) @(posedge clk);
    #1 trip_clr = 2'b10;
    @(posedge clk);
    #1 trip_clr = 2'b00;
    chk("collide pulse", int'(rev_pulse), 1);
    chk_out("collide", 1, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1 reed = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    for (int r = 0; r < 39; r++) do_rev();
    chk_out("post collide residue", 1, 0, 1, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
